// File: rtl/report_collector_c0.sv
// Report collector: stamps non-zero report vectors with a cycle count, queues them in a FIFO
// and serializes each set report bit as one record over a valid/ready handshake.
module report_collector_c0 #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [7:0]       report_vec,
    input  logic [7:0]       in_symbols,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W+10:0] rpt_data,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = CNT_W + 16;

    typedef enum logic {StIdle, StEmit} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    logic [7:0]       hold_vec_q;
    logic [CNT_W-1:0] hold_stamp_q;
    logic [7:0]       hold_sym_q;

    logic       capture, full, empty, push, pop, drop;
    logic [7:0] vec_rest;
    logic [2:0] low_id;

    assign capture  = run && (report_vec != 8'h00);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    // A full FIFO still accepts a push when the serializer pops in the same cycle.
    assign push     = capture && (!full || pop);
    assign drop     = capture && full && !pop;
    assign vec_rest = hold_vec_q & (hold_vec_q - 8'd1);

    always_comb begin
        low_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hold_vec_q[i]) low_id = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cnt_q, report_vec, in_symbols};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vec_q   <= '0;
            hold_stamp_q <= '0;
            hold_sym_q   <= '0;
        end else if (pop) begin
            {hold_stamp_q, hold_vec_q, hold_sym_q} <= mem_q[rd_ptr_q];
        end else if (state_q == StEmit && rpt_ready) begin
            hold_vec_q <= vec_rest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!empty) state_d = StEmit;
            StEmit: if (rpt_ready && vec_rest == 8'h00) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rpt_valid = (state_q == StEmit);
        pop       = (state_q == StIdle) && !empty;
        rpt_data  = rpt_valid ? {hold_stamp_q, low_id, hold_sym_q} : '0;
    end

endmodule
